// File: rtl/psram_qpi_responder.sv
// Behavioural-synthesisable QSPI PSRAM responder: SPI power-up (RSTEN/RST/QPI), QPI 0x38 write, 0xEB read.
// Build option: define PSRAM_PAGE_WRAP_EN to wrap burst addresses inside PAGE_BYTES-aligned pages.
module psram_qpi_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 6,
  parameter int PAGE_BYTES  = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck_en,
  input  logic       ce_n,
  input  logic [3:0] sio_in,
  output logic [3:0] sio_out,
  output logic       sio_oe,
  output logic       qpi_mode,
  output logic       busy
);

  // state     | meaning
  // ST_IDLE   | frame not started (waiting for first qualified cycle)
  // ST_SCMD   | SPI mode, shifting in the 8-bit command serially
  // ST_QCMD   | QPI mode, low command nibble pending (n=1)
  // ST_ADDR   | QPI address nibbles n=2..7
  // ST_WAIT   | read dummy cycles
  // ST_RD     | read data streaming
  // ST_WR     | write data streaming
  // ST_IGNORE | frame finished or unknown command, wait for ce_n high
  typedef enum logic [2:0] {
    ST_IDLE, ST_SCMD, ST_QCMD, ST_ADDR, ST_WAIT, ST_RD, ST_WR, ST_IGNORE
  } state_t;

  localparam int CNT_W = $clog2(WAIT_CYCLES + 9);
  localparam logic [CNT_W-1:0] LAST_CMD  = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(7 + WAIT_CYCLES);
`ifdef PSRAM_PAGE_WRAP_EN
  localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'(PAGE_BYTES - 1);
`else
  localparam logic [ADDR_W-1:0] WRAP_MASK = '1;
`endif

  if (ADDR_W < 5 || ADDR_W > 24) begin : g_bad_addr_w
    $error("ADDR_W must be in 5..24");
  end
  if (PAGE_BYTES < 2 || (PAGE_BYTES & (PAGE_BYTES - 1)) != 0) begin : g_bad_page
    $error("PAGE_BYTES must be a power of two");
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        sh_q, sh_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              half_q, half_d;
  logic [3:0]        out_q, out_d;
  logic              oe_q, oe_d;
  logic              qpi_q, qpi_d;
  logic              rsten_q, rsten_d;
  logic              busy_q, busy_d;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        spi_byte;
  logic [7:0]        qpi_cmd;
  logic [ADDR_W-1:0] addr_nx;

  logic [7:0] mem_q [2**ADDR_W];

  // Masked increment: bits outside WRAP_MASK hold, bits inside roll over.
  function automatic logic [ADDR_W-1:0] inc_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] n;
    n = a + 1'b1;
    return (a & ~WRAP_MASK) | (n & WRAP_MASK);
  endfunction

  always_comb begin
    spi_byte  = {sh_q, sio_in[0]};
    qpi_cmd   = {sh_q[3:0], sio_in};
    addr_nx   = {addr_q[ADDR_W-5:0], sio_in};
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    half_d    = half_q;
    out_d     = out_q;
    oe_d      = oe_q;
    qpi_d     = qpi_q;
    rsten_d   = rsten_q;
    mem_we    = 1'b0;
    mem_wdata = {sh_q[3:0], sio_in};

    if (ce_n) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      half_d  = 1'b0;
      oe_d    = 1'b0;
    end else if (sck_en) begin
      cnt_d = cnt_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (qpi_q) begin
            sh_d    = {3'b000, sio_in};
            state_d = ST_QCMD;
          end else begin
            sh_d    = {sh_q[5:0], sio_in[0]};
            state_d = ST_SCMD;
          end
        end
        ST_SCMD: begin
          sh_d = {sh_q[5:0], sio_in[0]};
          if (cnt_q == LAST_CMD) begin
            state_d = ST_IGNORE;
            case (spi_byte)
              8'h66: rsten_d = 1'b1;
              8'h99: if (rsten_q) begin
                qpi_d   = 1'b0;
                rsten_d = 1'b0;
              end
              8'h35: qpi_d = 1'b1;
              default: ;
            endcase
          end
        end
        ST_QCMD: begin
          state_d = ST_IGNORE;
          case (qpi_cmd)
            8'h38: begin
              rd_d    = 1'b0;
              state_d = ST_ADDR;
            end
            8'hEB: begin
              rd_d    = 1'b1;
              state_d = ST_ADDR;
            end
            8'hF5: qpi_d = 1'b0;
            8'h66: rsten_d = 1'b1;
            8'h99: if (rsten_q) begin
              qpi_d   = 1'b0;
              rsten_d = 1'b0;
            end
            default: ;
          endcase
        end
        ST_ADDR: begin
          // Shifting all six nibbles through keeps only the low ADDR_W address bits.
          addr_d = addr_nx;
          if (cnt_q == LAST_CMD) begin
            half_d = 1'b0;
            if (!rd_q) begin
              state_d = ST_WR;
            end else if (WAIT_CYCLES == 0) begin
              state_d = ST_RD;
              oe_d    = 1'b1;
              out_d   = mem_q[addr_nx][7:4];
              half_d  = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == LAST_WAIT) begin
            state_d = ST_RD;
            oe_d    = 1'b1;
            out_d   = mem_q[addr_q][7:4];
            half_d  = 1'b1;
          end
        end
        ST_RD: begin
          if (half_q) begin
            out_d  = mem_q[addr_q][3:0];
            addr_d = inc_addr(addr_q);
            half_d = 1'b0;
          end else begin
            out_d  = mem_q[addr_q][7:4];
            half_d = 1'b1;
          end
        end
        ST_WR: begin
          if (half_q) begin
            mem_we = 1'b1;
            addr_d = inc_addr(addr_q);
            half_d = 1'b0;
          end else begin
            sh_d   = {sh_q[6:4], sio_in};
            half_d = 1'b1;
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE) && (state_d != ST_IGNORE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      half_q  <= 1'b0;
      out_q   <= 4'h0;
      oe_q    <= 1'b0;
      qpi_q   <= 1'b0;
      rsten_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      half_q  <= half_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      qpi_q   <= qpi_d;
      rsten_q <= rsten_d;
      busy_q  <= busy_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[addr_q] <= mem_wdata;
    end
  end

  assign sio_out  = out_q;
  assign sio_oe   = oe_q;
  assign qpi_mode = qpi_q;
  assign busy     = busy_q;

endmodule
